pipe_perf_monitor: RTL

Synthesizable event-count monitor that sits beside the pipelined CPU and counts cycles plus a parametrised set of per-cycle hazard events (stall, flush, and similar). It is the in-design successor to bench-side stall/flush counting. Counting can be gated and snapshotted, and a programmable cycle limit raises a completion flag. This gives simulation and FPGA runs identical, cycle-exact performance figures without hierarchical probing.

---
 rtl/perf_pkg.sv | 19 +
 rtl/perf_sat_counter.sv | 42 ++++
 rtl/pipe_perf_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared types and defaults for the pipeline performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One overflow flag per event channel plus one for the cycle counter.
  function automatic int ovf_width(input int num_evt);
    return num_evt + 1;
  endfunction

  localparam int DEF_NUM_EVT = 4;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_OVF_W   = ovf_width(DEF_NUM_EVT);

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
module perf_sat_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_at_max;

  assign w_at_max = &r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (inc_i) begin
      // An increment attempted at all-ones is the saturation event: hold value, flag it.
      if (w_at_max) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle and per-channel hazard-event counting with gating, snapshot and a cycle limit.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT = DEF_NUM_EVT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     clr_i,
  input  logic [NUM_EVT-1:0]       evt_i,
  input  logic [CNT_W-1:0]         limit_i,
  input  logic                     snap_i,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt_o,
  output logic [NUM_EVT:0]         ovf_o,
  output logic [CNT_W-1:0]         snap_cycle_o,
  output logic [NUM_EVT*CNT_W-1:0] snap_evt_o,
  output logic                     snap_valid_o,
  output logic                     done_o,
  output logic                     busy_o
);

  localparam int OVF_W = ovf_width(NUM_EVT);

  state_e                   r_state;
  logic [CNT_W-1:0]         r_limit;
  logic                     r_done;
  logic [CNT_W-1:0]         r_snap_cycle;
  logic [NUM_EVT*CNT_W-1:0] r_snap_evt;
  logic                     r_snap_valid;

  logic                     w_active;
  logic [NUM_EVT-1:0]       w_evt_inc;
  logic [CNT_W-1:0]         w_cycle_cnt;
  logic [CNT_W-1:0]         w_cycle_next;
  logic [NUM_EVT*CNT_W-1:0] w_evt_cnt;
  logic [OVF_W-1:0]         w_ovf;
  logic                     w_limit_hit;

  assign w_active     = (r_state == ST_RUN) && start_i;
  assign w_cycle_next = w_cycle_cnt + 1'b1;
  // A saturated cycle counter wraps w_cycle_next to 0, which never matches a non-zero limit.
  assign w_limit_hit  = w_active && (r_limit != '0) && (w_cycle_next == r_limit);

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    w_evt_inc = '0;
    if (w_active) begin
      w_evt_inc = evt_i;
    end
  end

  perf_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (w_active),
    .cnt_o (w_cycle_cnt),
    .ovf_o (w_ovf[NUM_EVT])
  );

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    perf_sat_counter #(.CNT_W(CNT_W)) u_evt_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_i),
      .inc_i (w_evt_inc[k]),
      .cnt_o (w_evt_cnt[k*CNT_W +: CNT_W]),
      .ovf_o (w_ovf[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      r_state <= ST_IDLE;
      r_limit <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_limit <= limit_i;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_limit_hit) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture outranks clear so a simultaneous clear still snapshots the pre-clear counts.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_snap_cycle <= '0;
      r_snap_evt   <= '0;
      r_snap_valid <= 1'b0;
    end else if (snap_i) begin
      r_snap_cycle <= w_cycle_cnt;
      r_snap_evt   <= w_evt_cnt;
      r_snap_valid <= 1'b1;
    end else if (clr_i) begin
      r_snap_cycle <= '0;
      r_snap_evt   <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;
    end
  end

  assign cycle_cnt_o  = w_cycle_cnt;
  assign evt_cnt_o    = w_evt_cnt;
  assign ovf_o        = w_ovf;
  assign snap_cycle_o = r_snap_cycle;
  assign snap_evt_o   = r_snap_evt;
  assign snap_valid_o = r_snap_valid;
  assign done_o       = r_done;
  assign busy_o       = (r_state == ST_RUN);

endmodule
